// File: rtl/gerenciador_ativos_fila.sv
// gerenciador_ativos_fila: queues node update requests and dispatches each one
// to an active-node (NA) slot. A request goes to the slot that already holds
// its address, or else to the lowest free slot, which is then awaited until it
// reports active. Deactivation requests release every active slot whose
// address matches.
// Optional feature macro: GA_COALESCE_EN. When defined, an update whose
// address is already queued rewrites that entry's predecessor in place
// instead of appending a new entry.
module gerenciador_ativos_fila #(
  parameter int NUM_NA     = 8,
  parameter int ADR_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              atualizar_in,
  input  logic                              desativar_in,
  input  logic [ADR_WIDTH-1:0]              endereco_in,
  input  logic [ADR_WIDTH-1:0]              anterior_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0]       na_endereco_in,
  input  logic [NUM_NA-1:0]                 na_ativo_in,
  output logic [NUM_NA-1:0]                 ga_habilitar_out,
  output logic [NUM_NA-1:0]                 ga_desativar_out,
  output logic [ADR_WIDTH-1:0]              ga_endereco_out,
  output logic [ADR_WIDTH-1:0]              ga_anterior_out,
  output logic                              ga_pronto_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   ga_ocupacao_out,
  output logic                              ga_conflito_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SEL_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  typedef enum logic [2:0] {
    OCIOSO,
    BUSCA,
    HABILITA,
    ESPERA_LIVRE,
    ESPERA_ATIVO
  } estado_t;

  // Request queue storage and bookkeeping
  logic [ADR_WIDTH-1:0] fila_end_q [FIFO_DEPTH];
  logic [ADR_WIDTH-1:0] fila_ant_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  // Dispatch state and registered outputs
  estado_t              estado_q;
  logic [NUM_NA-1:0]    habilitar_q;
  logic [NUM_NA-1:0]    desativar_q;
  logic [ADR_WIDTH-1:0] endereco_q, anterior_q;
  logic                 conflito_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 hit_q;

  // Combinational helpers
  logic                 fila_cheia;
  logic                 push, pop;
  logic [ADR_WIDTH-1:0] head_end, head_ant;
  logic                 hit_found, free_found;
  logic [SEL_W-1:0]     hit_idx, free_idx, sel_idx;
  logic                 sel_valid, sel_bloqueado;
  logic [NUM_NA-1:0]    sel_onehot;
  logic [NUM_NA-1:0]    desativar_d;

  assign fila_cheia = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_end   = fila_end_q[rd_ptr_q];
  assign head_ant   = fila_ant_q[rd_ptr_q];
  assign pop        = (estado_q == HABILITA);

`ifdef GA_COALESCE_EN
  logic [FIFO_DEPTH-1:0] coal_match;
  logic                  coal_hit;

  // Look for a queued copy of the incoming address. The head is skipped: it
  // may already be latched for dispatch, so rewriting it could be lost.
  always_comb begin
    logic [PTR_W-1:0] off;
    coal_match = '0;
    off        = '0;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      off = PTR_W'(j) - rd_ptr_q;
      if ((off != '0) && (CNT_W'(off) < count_q) && (fila_end_q[j] == endereco_in))
        coal_match[j] = 1'b1;
    end
  end

  assign coal_hit = |coal_match;
  assign push     = atualizar_in && !desativar_in && !coal_hit && !fila_cheia;
`else
  assign push     = atualizar_in && !desativar_in && !fila_cheia;
`endif

  // Slot selection for the queue head (hit first, then lowest free slot) and
  // the release mask for a deactivation request
  always_comb begin
    hit_found   = 1'b0;
    hit_idx     = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    desativar_d = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (na_ativo_in[i] && (na_endereco_in[ADR_WIDTH*i +: ADR_WIDTH] == head_end) && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = SEL_W'(i);
      end
      if (!na_ativo_in[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
      desativar_d[i] = desativar_in && na_ativo_in[i] &&
                       (na_endereco_in[ADR_WIDTH*i +: ADR_WIDTH] == endereco_in);
    end
  end

  assign sel_valid     = hit_found || free_found;
  assign sel_idx       = hit_found ? hit_idx : free_idx;
  assign sel_onehot    = NUM_NA'(1) << sel_idx;
  // An enable must not coincide with a release of the same slot.
  assign sel_bloqueado = |(desativar_d & sel_onehot);

  // Queue write, pop and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        fila_end_q[j] <= '0;
        fila_ant_q[j] <= '0;
      end
    end else begin
      if (push) begin
        fila_end_q[wr_ptr_q] <= endereco_in;
        fila_ant_q[wr_ptr_q] <= anterior_in;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
`ifdef GA_COALESCE_EN
      if (atualizar_in && !desativar_in) begin
        for (int unsigned j = 0; j < FIFO_DEPTH; j++)
          if (coal_match[j]) fila_ant_q[j] <= anterior_in;
      end
`endif
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Release pulses and conflict flag, registered one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desativar_q <= '0;
      conflito_q  <= 1'b0;
    end else begin
      desativar_q <= desativar_d;
      conflito_q  <= atualizar_in && desativar_in;
    end
  end

  // Dispatch FSM with registered enable, address and predecessor outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      habilitar_q <= '0;
      endereco_q  <= '0;
      anterior_q  <= '0;
      sel_q       <= '0;
      hit_q       <= 1'b0;
    end else begin
      habilitar_q <= '0;
      case (estado_q)
        OCIOSO: begin
          if (count_q != '0) estado_q <= BUSCA;
        end
        BUSCA, ESPERA_LIVRE: begin
          if (sel_valid && !sel_bloqueado) begin
            habilitar_q <= sel_onehot;
            endereco_q  <= head_end;
            anterior_q  <= head_ant;
            sel_q       <= sel_idx;
            hit_q       <= hit_found;
            estado_q    <= HABILITA;
          end else if (!sel_valid) begin
            estado_q <= ESPERA_LIVRE;
          end
        end
        HABILITA: begin
          endereco_q <= '0;
          anterior_q <= '0;
          estado_q   <= hit_q ? OCIOSO : ESPERA_ATIVO;
        end
        ESPERA_ATIVO: begin
          if (na_ativo_in[sel_q]) estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign ga_habilitar_out = habilitar_q;
  assign ga_desativar_out = desativar_q;
  assign ga_endereco_out  = endereco_q;
  assign ga_anterior_out  = anterior_q;
  assign ga_conflito_out  = conflito_q;
  assign ga_ocupacao_out  = count_q;
  assign ga_pronto_out    = !fila_cheia;

endmodule

// File: tb/tb_gerenciador_ativos_fila.sv
// Testbench for gerenciador_ativos_fila (NUM_NA=8, ADR_WIDTH=5, FIFO_DEPTH=4).
// The bench also plays the NA slots: an allocated slot turns active a few
// cycles after its enable, and a released slot turns inactive.
module tb_gerenciador_ativos_fila;

  localparam int NNA   = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            atualizar_in, desativar_in;
  logic [AW-1:0]   endereco_in, anterior_in;
  logic [AW*NNA-1:0] na_endereco_in;
  logic [NNA-1:0]  na_ativo_in;
  logic [NNA-1:0]  ga_habilitar_out, ga_desativar_out;
  logic [AW-1:0]   ga_endereco_out, ga_anterior_out;
  logic            ga_pronto_out;
  logic [2:0]      ga_ocupacao_out;
  logic            ga_conflito_out;

  always #5 clk = ~clk;

  gerenciador_ativos_fila #(.NUM_NA(NNA), .ADR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .atualizar_in(atualizar_in), .desativar_in(desativar_in),
    .endereco_in(endereco_in), .anterior_in(anterior_in),
    .na_endereco_in(na_endereco_in), .na_ativo_in(na_ativo_in),
    .ga_habilitar_out(ga_habilitar_out), .ga_desativar_out(ga_desativar_out),
    .ga_endereco_out(ga_endereco_out), .ga_anterior_out(ga_anterior_out),
    .ga_pronto_out(ga_pronto_out), .ga_ocupacao_out(ga_ocupacao_out),
    .ga_conflito_out(ga_conflito_out)
  );

  // NA slot model state
  logic [NNA-1:0] na_act_m;
  logic [AW-1:0]  na_adr_m [NNA];
  logic [NNA-1:0] pre_act;
  logic [AW-1:0]  pre_adr [NNA];
  int             pre_seq, pre_done;
  bit             auto_act;
  int             pend_slot, pend_wait;
  logic [AW-1:0]  pend_addr;

  always_comb begin
    na_endereco_in = '0;
    for (int i = 0; i < NNA; i++) na_endereco_in[AW*i +: AW] = na_adr_m[i];
  end
  assign na_ativo_in = na_act_m;

  // Reference model: in-order request queue plus per-cycle expectations
  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] p;
  } req_t;
  req_t        exp_q[$];
  int          mcount;
  logic [7:0]  exp_des;
  logic        exp_conf;

  int n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int pick_slot(input logic [AW-1:0] a);
    for (int i = 0; i < NNA; i++) if (na_act_m[i] && na_adr_m[i] == a) return i;
    for (int i = 0; i < NNA; i++) if (!na_act_m[i]) return i;
    return -1;
  endfunction

  // Runs at every falling edge: compare outputs, update NA model, predict
  task automatic mon_step();
    req_t r;
    int   s, found, j0;
    bit   popped;
    if (!rst_n) begin
      exp_q.delete();
      mcount = 0; exp_des = '0; exp_conf = 1'b0; pend_slot = -1;
      if (pre_seq != pre_done) begin
        na_act_m = pre_act; na_adr_m = pre_adr; pre_done = pre_seq;
      end
      return;
    end
    chk("ocupacao", 32'(ga_ocupacao_out), 32'(mcount));
    chk("pronto", 32'(ga_pronto_out), 32'(mcount != DEPTH));
    chk("desativar", 32'(ga_desativar_out), 32'(exp_des));
    chk("conflito", 32'(ga_conflito_out), 32'(exp_conf));
    chk("hab_des_overlap", 32'(ga_habilitar_out & ga_desativar_out), 32'h0);
    popped = 1'b0;
    if (ga_habilitar_out != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_enable", 32'(ga_habilitar_out), 32'h0);
      end else begin
        r = exp_q.pop_front();
        popped = 1'b1;
        s = pick_slot(r.a);
        chk("habilitar", 32'(ga_habilitar_out), (s >= 0) ? (32'h1 << s) : 32'h0);
        chk("endereco", 32'(ga_endereco_out), 32'(r.a));
        chk("anterior", 32'(ga_anterior_out), 32'(r.p));
        if (s >= 0 && !na_act_m[s]) begin
          pend_slot = s; pend_addr = r.a; pend_wait = $urandom_range(0, 3);
        end
      end
    end
    // NA behaviour
    na_act_m = na_act_m & ~ga_desativar_out;
    if (pend_slot >= 0 && auto_act) begin
      if (pend_wait == 0) begin
        na_act_m[pend_slot] = 1'b1;
        na_adr_m[pend_slot] = pend_addr;
        pend_slot = -1;
      end else pend_wait--;
    end
    if (pre_seq != pre_done) begin
      na_act_m = pre_act; na_adr_m = pre_adr; pre_done = pre_seq;
    end
    // Predictions for the next rising edge
    exp_conf = atualizar_in && desativar_in;
    exp_des = '0;
    if (desativar_in)
      for (int i = 0; i < NNA; i++)
        if (na_act_m[i] && na_adr_m[i] == endereco_in) exp_des[i] = 1'b1;
    if (atualizar_in && !desativar_in) begin
      found = -1;
      j0 = popped ? 0 : 1;
`ifdef GA_COALESCE_EN
      for (int j = j0; j < exp_q.size(); j++)
        if (found < 0 && exp_q[j].a == endereco_in) found = j;
`endif
      if (found >= 0) exp_q[found].p = anterior_in;
      else if (mcount != DEPTH) begin
        exp_q.push_back('{a: endereco_in, p: anterior_in});
        mcount++;
      end
    end
    if (popped) mcount--;
  endtask

  task automatic op(input logic atu, input logic des, input logic [AW-1:0] a, input logic [AW-1:0] p);
    atualizar_in = atu; desativar_in = des; endereco_in = a; anterior_in = p;
    @(posedge clk); #1;
    atualizar_in = 1'b0; desativar_in = 1'b0;
  endtask

  task automatic commit_na();
    pre_seq++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pend_slot >= 0) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 400) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
    idle(3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hab"}, 32'(ga_habilitar_out), 32'h0);
    chk({tag, "_des"}, 32'(ga_desativar_out), 32'h0);
    chk({tag, "_end"}, 32'(ga_endereco_out), 32'h0);
    chk({tag, "_ant"}, 32'(ga_anterior_out), 32'h0);
    chk({tag, "_conf"}, 32'(ga_conflito_out), 32'h0);
    chk({tag, "_ocup"}, 32'(ga_ocupacao_out), 32'h0);
    chk({tag, "_pronto"}, 32'(ga_pronto_out), 32'h1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; atualizar_in = 1'b0; desativar_in = 1'b0;
    endereco_in = '0; anterior_in = '0;
    na_act_m = '0; pre_act = '0; pre_seq = 0; pre_done = 0;
    for (int i = 0; i < NNA; i++) begin na_adr_m[i] = '0; pre_adr[i] = '0; end
    auto_act = 1'b1; pend_slot = -1; pend_wait = 0; pend_addr = '0;
    mcount = 0; exp_des = '0; exp_conf = 1'b0;

    fork
      forever @(negedge clk) mon_step();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // Allocation into an empty slot table, with latency check
    pre_act = '0;
    commit_na();
    atualizar_in = 1'b1; endereco_in = 5'd5; anterior_in = 5'd0;
    @(posedge clk); #1;
    atualizar_in = 1'b0;
    chk("lat_e0", 32'(ga_habilitar_out), 32'h0);
    @(posedge clk); #1;
    chk("lat_e1", 32'(ga_habilitar_out), 32'h0);
    @(posedge clk); #1;
    chk("lat_e2_hab", 32'(ga_habilitar_out), 32'h01);
    chk("lat_e2_end", 32'(ga_endereco_out), 32'd5);
    @(posedge clk); #1;
    chk("lat_e3", 32'(ga_habilitar_out), 32'h0);
    drain();

    // Hit on an active slot
    pre_act = 8'b0000_0101;
    for (int i = 0; i < NNA; i++) pre_adr[i] = 5'(20 + i);
    pre_adr[0] = 5'd5; pre_adr[2] = 5'd9;
    commit_na();
    op(1'b1, 1'b0, 5'd9, 5'd3);
    drain();

    // All slots busy: stall until slot 6 frees up
    pre_act = 8'hFF;
    for (int i = 0; i < NNA; i++) pre_adr[i] = 5'(20 + i);
    commit_na();
    op(1'b1, 1'b0, 5'd12, 5'd2);
    for (int k = 0; k < 6; k++) begin
      chk("stall_no_enable", 32'(ga_habilitar_out), 32'h0);
      idle(1);
    end
    pre_act = 8'hBF;
    commit_na();
    drain();

    // Queue fills while stalled; fifth update dropped
    pre_act = 8'hFF;
    for (int i = 0; i < NNA; i++) pre_adr[i] = 5'(20 + i);
    commit_na();
    op(1'b1, 1'b0, 5'd1, 5'd0);
    op(1'b1, 1'b0, 5'd2, 5'd0);
    op(1'b1, 1'b0, 5'd7, 5'd0);
    op(1'b1, 1'b0, 5'd3, 5'd0);
    op(1'b1, 1'b0, 5'd4, 5'd0);
    idle(2);
    chk("full_ocup", 32'(ga_ocupacao_out), 32'd4);
    chk("full_pronto", 32'(ga_pronto_out), 32'd0);
`ifdef GA_COALESCE_EN
    op(1'b1, 1'b0, 5'd7, 5'd1);
    idle(1);
    chk("coal_ocup", 32'(ga_ocupacao_out), 32'd4);
`endif
    pre_act = '0;
    commit_na();
    drain();

    // Update and deactivate together
    pre_act = 8'h01;
    for (int i = 0; i < NNA; i++) pre_adr[i] = 5'(20 + i);
    pre_adr[0] = 5'd5;
    commit_na();
    op(1'b1, 1'b1, 5'd5, 5'd2);
    chk("conf_des", 32'(ga_desativar_out), 32'h01);
    chk("conf_flag", 32'(ga_conflito_out), 32'h1);
    chk("conf_ocup", 32'(ga_ocupacao_out), 32'h0);
    idle(1);
    chk("conf_pulse_end", 32'(ga_conflito_out), 32'h0);
    idle(2);

    // Reset while waiting for an allocated slot to become active
    auto_act = 1'b0;
    pre_act = '0;
    commit_na();
    op(1'b1, 1'b0, 5'd3, 5'd1);
    op(1'b1, 1'b0, 5'd4, 5'd1);
    idle(6);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_act = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("post_reset_no_enable", 32'(ga_habilitar_out), 32'h0);
      idle(1);
    end

    // Randomized traffic
    pre_act = '0;
    for (int i = 0; i < NNA; i++) pre_adr[i] = '0;
    commit_na();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        int n;
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          op(1'b1, 1'b0, 5'($urandom_range(1, 6)), 5'($urandom_range(0, 31)));
          if ($urandom_range(0, 2) == 0) idle(1);
        end
        drain();
      end else begin
        op($urandom_range(0, 3) == 0, 1'b1, 5'($urandom_range(1, 6)), 5'($urandom_range(0, 31)));
        idle(2);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
